// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor slice.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_fullsub.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module fullsub_dataflow (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit unsigned subtractor, LSB first, one bit per clock.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout
);

    localparam int CNT_W = $clog2(N + 1);

    state_t             state;
    logic [N-1:0]       sh_a;
    logic [N-1:0]       sh_b;
    logic               borrow;
    logic [CNT_W-1:0]   cnt;
    logic               d_bit;
    logic               bo_bit;
    logic               last_bit;
    logic [N:0]         diff_ext;
    logic [N-1:0]       diff_next;

    fullsub_dataflow u_fullsub (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .bin  (borrow),
        .d    (d_bit),
        .bout (bo_bit)
    );

    // Concatenate-then-slice keeps the MSB-side shift legal for N = 1.
    always_comb begin
        diff_ext  = {d_bit, diff};
        diff_next = diff_ext[N:1];
        last_bit  = (cnt == CNT_W'(N - 1));
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sh_a   <= a;
                        sh_b   <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    diff   <= diff_next;
                    sh_a   <= sh_a >> 1;
                    sh_b   <= sh_b >> 1;
                    borrow <= bo_bit;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        state <= DONE;
                        bout  <= bo_bit;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at N = 8, 1 and 16.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        st8, st1, st16;
    logic [7:0]  a8, b8, d8;
    logic [0:0]  a1, b1, d1;
    logic [15:0] a16, b16, d16;
    logic        bz8, dn8, bo8, bz1, dn1, bo1, bz16, dn16, bo16;

    int n_vec = 0;
    int n_err = 0;
    int nw[3] = '{8, 1, 16};

    serial_subtractor #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8),
        .busy(bz8), .done(dn8), .diff(d8), .bout(bo8)
    );
    serial_subtractor #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1),
        .busy(bz1), .done(dn1), .diff(d1), .bout(bo1)
    );
    serial_subtractor #(.N(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .a(a16), .b(b16),
        .busy(bz16), .done(dn16), .diff(d16), .bout(bo16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int s, input logic st, input logic [15:0] av, input logic [15:0] bv);
        case (s)
            0: begin st8  = st; a8  = av[7:0]; b8  = bv[7:0]; end
            1: begin st1  = st; a1  = av[0:0]; b1  = bv[0:0]; end
            default: begin st16 = st; a16 = av; b16 = bv; end
        endcase
    endtask

    function automatic logic get_busy(input int s);
        return (s == 0) ? bz8 : (s == 1) ? bz1 : bz16;
    endfunction
    function automatic logic get_done(input int s);
        return (s == 0) ? dn8 : (s == 1) ? dn1 : dn16;
    endfunction
    function automatic logic get_bout(input int s);
        return (s == 0) ? bo8 : (s == 1) ? bo1 : bo16;
    endfunction
    function automatic logic [31:0] get_diff(input int s);
        return (s == 0) ? {24'd0, d8} : (s == 1) ? {31'd0, d1} : {16'd0, d16};
    endfunction

    // Called #1 after the accept edge; returns edges taken until done shows.
    task automatic wait_done(input int s, input int poke, output int cyc, output int busy_cnt);
        bit poked;
        cyc = 0;
        busy_cnt = 0;
        while (cyc < nw[s] + 4) begin
            poked = 0;
            if (get_busy(s)) busy_cnt++;
            if (cyc == poke) begin
                set_in(s, 1'b1, 16'h0001, 16'h0002);
                poked = 1;
            end
            @(posedge clk); #1;
            if (poked) set_in(s, 1'b0, 16'h0000, 16'h0000);
            cyc++;
            if (get_done(s)) break;
        end
    endtask

    task automatic do_op(input int s, input logic [15:0] av, input logic [15:0] bv, input int poke);
        logic [31:0] mask, ed, eb;
        int cyc, bc;
        mask = (32'd1 << nw[s]) - 32'd1;
        ed = ({16'd0, av} - {16'd0, bv}) & mask;
        eb = (({16'd0, av} & mask) < ({16'd0, bv} & mask)) ? 32'd1 : 32'd0;
        @(negedge clk);
        set_in(s, 1'b1, av, bv);
        @(posedge clk); #1;
        set_in(s, 1'b0, 16'($urandom), 16'($urandom));
        wait_done(s, poke, cyc, bc);
        chk("latency", cyc, nw[s]);
        chk("busy_cycles", bc, nw[s]);
        chk("done", get_done(s), 1);
        chk("diff", get_diff(s), ed);
        chk("bout", get_bout(s), eb);
        @(posedge clk); #1;
        chk("done_pulse_end", get_done(s), 0);
        chk("idle_after", get_busy(s), 0);
    endtask

    initial begin
        int cyc, bc, n;
        rst_n = 1'b0;
        set_in(0, 1'b0, 16'd0, 16'd0);
        set_in(1, 1'b0, 16'd0, 16'd0);
        set_in(2, 1'b0, 16'd0, 16'd0);
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) begin
            chk("rst_busy", get_busy(s), 0);
            chk("rst_done", get_done(s), 0);
            chk("rst_diff", get_diff(s), 0);
            chk("rst_bout", get_bout(s), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // N = 8 directed cases, including the busy-ignore poke on RUN cycle 3
        do_op(0, 16'd100, 16'd37, -1);
        do_op(0, 16'd5,   16'd9,  -1);
        do_op(0, 16'd0,   16'd1,  -1);
        do_op(0, 16'd255, 16'd255, -1);
        do_op(0, 16'd200, 16'd50, 2);

        // back-to-back with start held high
        @(negedge clk);
        set_in(0, 1'b1, 16'd10, 16'd3);
        @(posedge clk); #1;
        set_in(0, 1'b1, 16'd3, 16'd10);
        wait_done(0, -1, cyc, bc);
        chk("b2b_lat1", cyc, 8);
        chk("b2b_diff1", get_diff(0), 7);
        chk("b2b_bout1", get_bout(0), 0);
        @(posedge clk); #1;
        chk("b2b_relaunch_busy", get_busy(0), 1);
        chk("b2b_relaunch_done", get_done(0), 0);
        set_in(0, 1'b0, 16'd0, 16'd0);
        wait_done(0, -1, cyc, bc);
        chk("b2b_lat2", cyc, 8);
        chk("b2b_diff2", get_diff(0), 249);
        chk("b2b_bout2", get_bout(0), 1);
        @(posedge clk); #1;
        chk("b2b_done_end", get_done(0), 0);

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        set_in(0, 1'b1, 16'd123, 16'd45);
        @(posedge clk); #1;
        set_in(0, 1'b0, 16'd0, 16'd0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", get_busy(0), 0);
        chk("mid_rst_done", get_done(0), 0);
        chk("mid_rst_diff", get_diff(0), 0);
        chk("mid_rst_bout", get_bout(0), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (get_done(0)) n++;
        end
        chk("no_done_after_rst", n, 0);
        do_op(0, 16'd50, 16'd20, -1);

        // N = 1 exhaustive
        for (int i = 0; i < 4; i++)
            do_op(1, 16'(i & 1), 16'(i >> 1), -1);

        // N = 16 random against plain arithmetic
        for (int i = 0; i < 1000; i++)
            do_op(2, 16'($urandom), 16'($urandom), -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
